mem_bus_master: RTL and testbench
=================================

// Module: mem_bus_master
// PURPOSE
//   Initiator side of the asynchronous en/rdwr/ack memory handshake. Converts a
//   single-cycle CPU request (read or write, 12-bit word address, 16-bit data) into
//   a fully interlocked four-phase bus cycle, and drives the shared tri-state data bus.
//   Returns read data and a one-cycle done/err indication.
//   Sits between the CPU control unit and the 4096 x 16 main memory.
// PARAMETERS
//   SETUP_CYC    1    cycles addr/rdwr/wdata are stable before mem_en rises (>=1)
//   ACK_TIMEOUT  64   max cycles waited for each ack edge; 0 = wait forever
//   CNT_W        8    width of the setup/timeout counter (must hold both values)
// PORTS
//   clk        in   1   system clock, all state changes on rising edge
//   rst_n      in   1   synchronous reset, active low
//   req        in   1   start transaction; sampled only in IDLE
//   we         in   1   1 = write, 0 = read; captured with req
//   addr       in   12  word address; captured with req
//   wdata      in   16  write data; captured with req
//   rdata      out  16  last successfully read word
//   busy       out  1   high from the cycle after acceptance until back in IDLE
//   done       out  1   one-cycle pulse at end of every accepted transaction
//   err        out  1   valid with done: 1 = ack timeout occurred
//   mem_addr   out  12  memory address
//   mem_data   inout 16 shared data bus; driven only during write phases, else 'z
//   mem_rdwr   out  1   1 = write, 0 = read
//   mem_en     out  1   memory enable (request)
//   mem_ack    in   1   memory acknowledge; treated as synchronous to clk
// BEHAVIOUR
//   Reset (rst_n=0 at clock edge): state=IDLE; mem_en=0, mem_rdwr=0, mem_addr=0,
//     mem_data='z, rdata=0, busy=0, done=0, err=0, counter=0. Reset mid-transaction
//     aborts it: mem_en drops and bus releases on that same edge; no done pulse.
//   States: IDLE, SETUP, ACCESS, HOLD, RELEASE, DONE.
//   IDLE: req=1 -> latch we/addr/wdata, clear err, cnt=0, go SETUP. req while busy ignored.
//   SETUP: mem_addr/mem_rdwr = latched values, mem_en=0; write drives mem_data=wdata.
//     After SETUP_CYC cycles -> ACCESS.
//   ACCESS: mem_en=1, addr/rdwr/data held. mem_ack=1 sampled -> HOLD, cnt=0.
//     cnt reaches ACK_TIMEOUT with no ack -> err flag set, go RELEASE.
//   HOLD: mem_en=1 one cycle; on exit edge, a read loads rdata<=mem_data -> RELEASE.
//   RELEASE: mem_en=0; addr/rdwr and write data still held (hold time).
//     mem_ack=0 sampled -> DONE. Timeout as in ACCESS -> err set, go DONE.
//   DONE: done=1 for exactly one cycle, err valid; mem_data='z; -> IDLE (busy=0).
//   Latency: req sampled at edge E0 with zero-delay ack -> done high in cycle
//     E0+SETUP_CYC+4 (5 with defaults). Minimum req-to-req spacing SETUP_CYC+5.
//   Read timeout: rdata unchanged. Write never alters rdata.
//   mem_data never driven while mem_rdwr=0, nor in IDLE/DONE (no bus contention).
//   mem_rdwr changes only while mem_en=0.
//   req held high continuously: one transaction per pass through IDLE.
// TESTING
//   1 Reset: rst_n=0 two cycles mid-ACCESS -> next cycle mem_en=0, mem_data='z,
//     busy=0, rdata=0000; no done pulse.
//   2 Write: req, we=1, addr=12'h123, wdata=16'hBEEF; model acks -> mem_data=BEEF
//     whenever mem_en=1, done 5 cycles after accept, err=0; model mem[123]=BEEF.
//   3 Read-back: req we=0 addr=12'h123 -> rdata=BEEF on done, mem_data driven
//     by master in no cycle of the transaction.
//   4 Timeout: model never asserts ack, ACK_TIMEOUT=4 -> mem_en high 4 cycles,
//     then drops; done+err=1; rdata keeps previous value.
//   5 Slow ack: ack delayed 10 cycles rising and 3 falling -> done at 5+10+3 cycles,
//     err=0; addr/rdwr stable throughout mem_en=1.
//   6 Back-to-back: req held high, write 0x000=0001 then read 0xFFF (preloaded
//     A5A5) -> two done pulses, rdata=A5A5; req pulses while busy are ignored.

Source files
------------

// File: rtl/mem_bus_master.sv
// Initiator side of the four-phase en/rdwr/ack memory handshake.
// Turns a single-cycle CPU request into an interlocked bus cycle, drives the
// shared data bus only during write phases and reports done/err per transaction.
module mem_bus_master #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [11:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [11:0] o_mem_addr,
    inout  wire  [15:0] io_mem_data,
    output logic        o_mem_rdwr,
    output logic        o_mem_en,
    input  logic        i_mem_ack
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetup   = 3'd1,
        StAccess  = 3'd2,
        StHold    = 3'd3,
        StRelease = 3'd4,
        StDone    = 3'd5
    } state_e;

    // Terminal counts; a zero timeout disables the ack watchdog entirely.
    localparam int unsigned SetupLastInt = (SETUP_CYC == 0) ? 0 : SETUP_CYC - 1;
    localparam int unsigned ToLastInt    = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] SetupLast = CNT_W'(SetupLastInt);
    localparam logic [CNT_W-1:0] ToLast    = CNT_W'(ToLastInt);
    localparam logic             ToEnable  = (ACK_TIMEOUT != 0);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_accept;
    logic             w_timeout;
    logic             w_cnt_expired;
    logic             w_we_d;

    logic             r_we;
    logic [11:0]      r_addr;
    logic [15:0]      r_wdata;
    logic [15:0]      r_rdata;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_mem_en;
    logic             r_drive;

    assign w_accept      = (r_state == StIdle) && i_req;
    assign w_cnt_expired = ToEnable && (r_cnt == ToLast);
    // Direction that will be in force after this edge, used for the drive enable.
    assign w_we_d        = w_accept ? i_we : r_we;

    // State register and shared setup/timeout counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Next-state and counter logic for the handshake sequence.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_timeout = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_state_d = StSetup;
                    w_cnt_d   = '0;
                end
            end
            StSetup: begin
                if (r_cnt == SetupLast) begin
                    w_state_d = StAccess;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StAccess: begin
                if (i_mem_ack) begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end else if (w_cnt_expired) begin
                    w_timeout = 1'b1;
                    w_state_d = StRelease;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StHold: begin
                w_state_d = StRelease;
                w_cnt_d   = '0;
            end
            StRelease: begin
                if (!i_mem_ack) begin
                    w_state_d = StDone;
                    w_cnt_d   = '0;
                end else if (w_cnt_expired) begin
                    w_timeout = 1'b1;
                    w_state_d = StDone;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Request capture, error flag and read-data register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_err   <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Data is sampled at the end of HOLD, one full cycle after ack was seen.
            if ((r_state == StHold) && !r_we) begin
                r_rdata <= io_mem_data;
            end
        end
    end

    // Bus-facing controls registered from the next state so they never glitch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mem_en <= 1'b0;
            r_drive  <= 1'b0;
        end else begin
            r_busy   <= (w_state_d != StIdle);
            r_done   <= (w_state_d == StDone);
            r_mem_en <= (w_state_d == StAccess) || (w_state_d == StHold);
            r_drive  <= w_we_d && ((w_state_d == StSetup) || (w_state_d == StAccess) ||
                                   (w_state_d == StHold)  || (w_state_d == StRelease));
        end
    end

    assign io_mem_data = r_drive ? r_wdata : 16'hzzzz;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_mem_addr  = r_addr;
    assign o_mem_rdwr  = r_we;
    assign o_mem_en    = r_mem_en;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: a memory model with programmable ack delays
// on the main instance, and a second instance with a short ack timeout.
`timescale 1ns/1ps
module tb_mem_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy, done, err;
    logic [11:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_rdwr, mem_en;
    logic        mem_ack;

    logic        t_req, t_we;
    logic [11:0] t_addr;
    logic [15:0] t_wdata;
    logic [15:0] t_rdata;
    logic        t_busy, t_done, t_err;
    logic [11:0] t_mem_addr;
    wire  [15:0] t_mem_data;
    logic        t_mem_rdwr, t_mem_en;
    wire         t_mem_ack;
    logic        t_ack_en;

    int n_chk  = 0;
    int n_pass = 0;

    mem_bus_master u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_mem_addr  (mem_addr),
        .io_mem_data (mem_data),
        .o_mem_rdwr  (mem_rdwr),
        .o_mem_en    (mem_en),
        .i_mem_ack   (mem_ack)
    );

    mem_bus_master #(.ACK_TIMEOUT(4)) u_dut_to (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (t_req),
        .i_we        (t_we),
        .i_addr      (t_addr),
        .i_wdata     (t_wdata),
        .o_rdata     (t_rdata),
        .o_busy      (t_busy),
        .o_done      (t_done),
        .o_err       (t_err),
        .o_mem_addr  (t_mem_addr),
        .io_mem_data (t_mem_data),
        .o_mem_rdwr  (t_mem_rdwr),
        .o_mem_en    (t_mem_en),
        .i_mem_ack   (t_mem_ack)
    );

    // Timeout instance: zero-delay ack when enabled, constant read data.
    assign t_mem_ack  = t_ack_en & t_mem_en;
    assign t_mem_data = t_mem_rdwr ? 16'hzzzz : 16'h1234;

    // Main memory model: drives the bus on reads, acks after programmable delays.
    logic [15:0] mem [4096];
    int rise_dly = 0, fall_dly = 0, rise_cnt = 0, fall_cnt = 0;
    assign mem_data = mem_rdwr ? 16'hzzzz : mem[mem_addr];

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            rise_cnt = 0;
            fall_cnt = 0;
        end else if (mem_en && !mem_ack) begin
            fall_cnt = 0;
            if (rise_cnt >= rise_dly) begin
                mem_ack  = 1'b1;
                rise_cnt = 0;
                if (mem_rdwr) mem[mem_addr] = mem_data;
            end else begin
                rise_cnt++;
            end
        end else if (!mem_en && mem_ack) begin
            if (fall_cnt >= fall_dly) begin
                mem_ack  = 1'b0;
                fall_cnt = 0;
            end else begin
                fall_cnt++;
            end
        end
    end

    // Protocol monitors sampled mid-cycle.
    int          n_done = 0, en_cycles = 0, t_en_cycles = 0;
    int          stab_viol = 0, wbus_bad = 0, drv_bad = 0;
    logic [15:0] exp_wbus = 16'h0000;
    logic        p_en = 1'b0, p_rdwr = 1'b0;
    logic [11:0] p_addr = 12'h000;

    always @(negedge clk) begin
        if (done) n_done++;
        if (mem_en) en_cycles++;
        if (t_mem_en) t_en_cycles++;
        if (mem_en && p_en && ((mem_addr !== p_addr) || (mem_rdwr !== p_rdwr))) stab_viol++;
        if (mem_en && mem_rdwr && (mem_data !== exp_wbus)) wbus_bad++;
        if (!mem_rdwr && (mem_data !== mem[mem_addr])) drv_bad++;
        p_en   = mem_en;
        p_addr = mem_addr;
        p_rdwr = mem_rdwr;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_txn(input logic w, input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Cycles counted from the negedge just after the accept edge (that one is 1).
    task automatic wait_done(input int max, output int cyc);
        cyc = 1;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic t_start_read(input logic [11:0] a, output int cyc);
        @(negedge clk);
        t_req = 1'b1; t_we = 1'b0; t_addr = a;
        @(negedge clk);
        t_req = 1'b0;
        cyc = 1;
        while (!t_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int n0;
        n_chk++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", mem_en); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL rst_rdata got %h want 0000", rdata); else n_pass++;
        n_chk++; if (mem_addr !== 12'h000) $display("FAIL rst_addr got %h want 000", mem_addr); else n_pass++;
        n_chk++; if (mem_rdwr !== 1'b0) $display("FAIL rst_rdwr got %b want 0", mem_rdwr); else n_pass++;

        // Abort a write while it is stuck in ACCESS.
        rise_dly = 30;
        start_txn(1'b1, 12'h123, 16'hBEEF);
        for (int i = 0; i < 10 && !mem_en; i++) @(negedge clk);
        n_chk++; if (mem_en !== 1'b1) $display("FAIL rst_reach_access mem_en got %b want 1", mem_en); else n_pass++;
        n0 = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b0) $display("FAIL midrst_mem_en got %b want 0", mem_en); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rise_dly = 0;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL midrst_rdata got %h want 0000", rdata); else n_pass++;
        n_chk++; if (mem_data !== 16'h0F0F) $display("FAIL midrst_bus got %h want 0F0F (model only)", mem_data); else n_pass++;
        repeat (8) @(negedge clk);
        n_chk++; if (n_done !== n0) $display("FAIL midrst_no_done got %0d pulses want 0", n_done - n0); else n_pass++;
    endtask

    task automatic test_write();
        int cyc;
        exp_wbus = 16'hBEEF; wbus_bad = 0; en_cycles = 0;
        start_txn(1'b1, 12'h123, 16'hBEEF);
        wait_done(20, cyc);
        n_chk++; if (cyc !== 5 || done !== 1'b1) $display("FAIL wr_latency got %0d done=%b want 5", cyc, done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL wr_err got %b want 0", err); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL wr_busy_done got %b want 1", busy); else n_pass++;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL wr_rdata got %h want 0000", rdata); else n_pass++;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL wr_idle busy=%b done=%b want 0 0", busy, done); else n_pass++;
        n_chk++; if (wbus_bad !== 0) $display("FAIL wr_bus got %0d bad cycles want 0", wbus_bad); else n_pass++;
        n_chk++; if (en_cycles !== 2) $display("FAIL wr_en_len got %0d want 2", en_cycles); else n_pass++;
        n_chk++; if (mem[12'h123] !== 16'hBEEF) $display("FAIL wr_mem got %h want BEEF", mem[12'h123]); else n_pass++;
    endtask

    task automatic test_readback();
        int cyc;
        drv_bad = 0;
        start_txn(1'b0, 12'h123, 16'h5A5A);
        wait_done(20, cyc);
        n_chk++; if (cyc !== 5 || done !== 1'b1) $display("FAIL rd_latency got %0d done=%b want 5", cyc, done); else n_pass++;
        n_chk++; if (rdata !== 16'hBEEF) $display("FAIL rd_rdata got %h want BEEF", rdata); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rd_err got %b want 0", err); else n_pass++;
        @(negedge clk);
        n_chk++; if (drv_bad !== 0) $display("FAIL rd_bus_driven got %0d cycles want 0", drv_bad); else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        t_ack_en = 1'b1;
        t_start_read(12'h010, cyc);
        n_chk++; if (cyc !== 5 || t_err !== 1'b0) $display("FAIL to_preread cyc=%0d err=%b want 5 0", cyc, t_err); else n_pass++;
        n_chk++; if (t_rdata !== 16'h1234) $display("FAIL to_preread_rdata got %h want 1234", t_rdata); else n_pass++;
        t_ack_en = 1'b0;
        @(negedge clk);
        t_en_cycles = 0;
        t_start_read(12'h456, cyc);
        n_chk++; if (cyc !== 7 || t_done !== 1'b1) $display("FAIL to_latency got %0d done=%b want 7", cyc, t_done); else n_pass++;
        n_chk++; if (t_err !== 1'b1) $display("FAIL to_err got %b want 1", t_err); else n_pass++;
        n_chk++; if (t_en_cycles !== 4) $display("FAIL to_en_len got %0d want 4", t_en_cycles); else n_pass++;
        n_chk++; if (t_rdata !== 16'h1234) $display("FAIL to_rdata got %h want 1234", t_rdata); else n_pass++;
        @(negedge clk);
        n_chk++; if (t_busy !== 1'b0) $display("FAIL to_idle busy got %b want 0", t_busy); else n_pass++;
    endtask

    task automatic test_slow_ack();
        int cyc;
        rise_dly = 10; fall_dly = 3;
        exp_wbus = 16'h1357; wbus_bad = 0; stab_viol = 0;
        start_txn(1'b1, 12'h3C4, 16'h1357);
        wait_done(60, cyc);
        n_chk++; if (cyc !== 18 || done !== 1'b1) $display("FAIL slow_latency got %0d done=%b want 18", cyc, done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL slow_err got %b want 0", err); else n_pass++;
        @(negedge clk);
        n_chk++; if (stab_viol !== 0) $display("FAIL slow_stable got %0d violations want 0", stab_viol); else n_pass++;
        n_chk++; if (wbus_bad !== 0) $display("FAIL slow_bus got %0d bad cycles want 0", wbus_bad); else n_pass++;
        n_chk++; if (mem[12'h3C4] !== 16'h1357) $display("FAIL slow_mem got %h want 1357", mem[12'h3C4]); else n_pass++;
        rise_dly = 0; fall_dly = 0;
    endtask

    task automatic test_back_to_back();
        int n0, cyc1, cyc2;
        exp_wbus = 16'h0001; drv_bad = 0;
        @(negedge clk);
        n0 = n_done;
        req = 1'b1; we = 1'b1; addr = 12'h000; wdata = 16'h0001;
        cyc1 = 0;
        while (!done && cyc1 < 20) begin
            @(negedge clk);
            cyc1++;
        end
        n_chk++; if (cyc1 !== 5 || err !== 1'b0) $display("FAIL b2b_first cyc=%0d err=%b want 5 0", cyc1, err); else n_pass++;
        we = 1'b0; addr = 12'hFFF; wdata = 16'hFFFF;
        cyc2 = 0;
        @(negedge clk);
        cyc2++;
        while (!done && cyc2 < 20) begin
            @(negedge clk);
            cyc2++;
        end
        req = 1'b0;
        n_chk++; if (cyc2 !== 6) $display("FAIL b2b_spacing got %0d want 6", cyc2); else n_pass++;
        n_chk++; if (rdata !== 16'hA5A5) $display("FAIL b2b_rdata got %h want A5A5", rdata); else n_pass++;
        repeat (10) @(negedge clk);
        n_chk++; if (n_done - n0 !== 2) $display("FAIL b2b_done_count got %0d want 2", n_done - n0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle busy got %b want 0", busy); else n_pass++;
        n_chk++; if (mem[12'h000] !== 16'h0001) $display("FAIL b2b_mem got %h want 0001", mem[12'h000]); else n_pass++;
        n_chk++; if (drv_bad !== 0) $display("FAIL b2b_bus_driven got %0d cycles want 0", drv_bad); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h0F0F;
        mem[12'hFFF] = 16'hA5A5;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 12'h000; wdata = 16'h0000;
        t_req = 1'b0; t_we = 1'b0; t_addr = 12'h000; t_wdata = 16'h0000; t_ack_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write();
        test_readback();
        test_timeout();
        test_slow_ack();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
